// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register: filters the raw data-memory word for the load size,
// registers the writeback fields, and keeps a sticky halt plus a retired-instruction count.
module mem_wb_latch #(
    parameter int BITS_SIZE = 32,
    parameter int REG_ADDR  = 5
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic [BITS_SIZE-1:0] i_mem_data,
    input  logic [1:0]           i_addr_low,
    input  logic [1:0]           i_load_size,
    input  logic                 i_load_unsigned,
    input  logic [BITS_SIZE-1:0] i_alu_result,
    input  logic [BITS_SIZE-1:0] i_extension,
    input  logic [BITS_SIZE-1:0] i_pc8,
    input  logic [REG_ADDR-1:0]  i_rd,
    input  logic                 i_reg_write,
    input  logic                 i_mem_to_reg,
    input  logic                 i_lui,
    input  logic                 i_jal,
    input  logic                 i_halt,
    output logic [BITS_SIZE-1:0] o_filterL,
    output logic [BITS_SIZE-1:0] o_extension,
    output logic [BITS_SIZE-1:0] o_alu_result,
    output logic [BITS_SIZE-1:0] o_pc8,
    output logic [REG_ADDR-1:0]  o_rd,
    output logic                 o_reg_write,
    output logic                 o_mem_to_reg,
    output logic                 o_lui,
    output logic                 o_jal,
    output logic                 o_valid,
    output logic                 o_misaligned,
    output logic                 o_halt,
    output logic [BITS_SIZE-1:0] o_retired
);

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;

    // Little-endian lane select followed by sign or zero extension; sizes 10/11 pass the word.
    function automatic logic [BITS_SIZE-1:0] load_filter(
        input logic [BITS_SIZE-1:0] data,
        input logic [1:0]           addr,
        input logic [1:0]           size,
        input logic                 uns
    );
        logic [BITS_SIZE-1:0] sh;
        logic [BITS_SIZE-1:0] res;
        sh  = data >> {addr, 3'b000};
        res = data;
        case (size)
            LS_BYTE: res = {{(BITS_SIZE-8){~uns & sh[7]}}, sh[7:0]};
            LS_HALF: begin
                sh  = data >> {addr[1], 4'b0000};
                res = {{(BITS_SIZE-16){~uns & sh[15]}}, sh[15:0]};
            end
            default: res = data;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(
        input logic       is_load,
        input logic [1:0] addr,
        input logic [1:0] size
    );
        logic mis;
        case (size)
            LS_BYTE: mis = 1'b0;
            LS_HALF: mis = addr[0];
            default: mis = (addr != 2'b00);
        endcase
        return is_load & mis;
    endfunction

    logic [BITS_SIZE-1:0] r_filterL;
    logic [BITS_SIZE-1:0] r_extension;
    logic [BITS_SIZE-1:0] r_alu_result;
    logic [BITS_SIZE-1:0] r_pc8;
    logic [REG_ADDR-1:0]  r_rd;
    logic                 r_reg_write;
    logic                 r_mem_to_reg;
    logic                 r_lui;
    logic                 r_jal;
    logic                 r_valid;
    logic                 r_misaligned;
    logic                 r_halt;
    logic [BITS_SIZE-1:0] r_retired;

    logic                 w_cap;
    logic                 w_bubble;
    logic                 w_mis;
    logic [BITS_SIZE-1:0] w_filter;

    // Capture/bubble decisions and the filtered load word ahead of the register.
    always_comb begin
        w_cap    = i_enable & ~r_halt;
        w_bubble = i_flush | ~i_valid;
        w_mis    = is_misaligned(i_mem_to_reg, i_addr_low, i_load_size);
        if (w_mis) begin
            w_filter = {BITS_SIZE{1'b0}};
        end else begin
            w_filter = load_filter(i_mem_data, i_addr_low, i_load_size, i_load_unsigned);
        end
    end

    // Pipeline register; once halt is captured nothing changes until reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_filterL    <= {BITS_SIZE{1'b0}};
            r_extension  <= {BITS_SIZE{1'b0}};
            r_alu_result <= {BITS_SIZE{1'b0}};
            r_pc8        <= {BITS_SIZE{1'b0}};
            r_rd         <= {REG_ADDR{1'b0}};
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_lui        <= 1'b0;
            r_jal        <= 1'b0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
            r_halt       <= 1'b0;
            r_retired    <= {BITS_SIZE{1'b0}};
        end else if (w_cap) begin
            if (w_bubble) begin
                r_filterL    <= {BITS_SIZE{1'b0}};
                r_extension  <= {BITS_SIZE{1'b0}};
                r_alu_result <= {BITS_SIZE{1'b0}};
                r_pc8        <= {BITS_SIZE{1'b0}};
                r_rd         <= {REG_ADDR{1'b0}};
                r_reg_write  <= 1'b0;
                r_mem_to_reg <= 1'b0;
                r_lui        <= 1'b0;
                r_jal        <= 1'b0;
                r_valid      <= 1'b0;
                r_misaligned <= 1'b0;
            end else begin
                r_filterL    <= w_filter;
                r_extension  <= i_extension;
                r_alu_result <= i_alu_result;
                r_pc8        <= i_pc8;
                r_rd         <= i_rd;
                r_reg_write  <= i_reg_write & ~w_mis;
                r_mem_to_reg <= i_mem_to_reg;
                r_lui        <= i_lui;
                r_jal        <= i_jal;
                r_valid      <= 1'b1;
                r_misaligned <= w_mis;
                r_halt       <= i_halt;
                r_retired    <= r_retired + {{(BITS_SIZE-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_filterL    = r_filterL;
    assign o_extension  = r_extension;
    assign o_alu_result = r_alu_result;
    assign o_pc8        = r_pc8;
    assign o_rd         = r_rd;
    assign o_reg_write  = r_reg_write;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_lui        = r_lui;
    assign o_jal        = r_jal;
    assign o_valid      = r_valid;
    assign o_misaligned = r_misaligned;
    assign o_halt       = r_halt;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_mem_wb_latch.sv
// Bench for mem_wb_latch: directed load-filter, stall, flush, halt and wrap cases,
// then randomized traffic against a behavioural model of the writeback register.
module tb_mem_wb_latch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, fl, vld, luns, rw, m2r, lui, jal, hlt;
    logic [31:0] mdata, alu, ext, pc8;
    logic [1:0]  alow, lsize;
    logic [4:0]  rd;

    logic [31:0] o_filterL, o_extension, o_alu_result, o_pc8, o_retired;
    logic [4:0]  o_rd;
    logic        o_reg_write, o_mem_to_reg, o_lui, o_jal, o_valid, o_misaligned, o_halt;

    // Reference model state: what the WB stage should be holding.
    logic [31:0] m_filter, m_ext, m_alu, m_pc8, m_ret;
    logic [4:0]  m_rd;
    logic        m_rw, m_m2r, m_lui, m_jal, m_valid, m_mis, m_halt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_wb_latch #(.BITS_SIZE(32), .REG_ADDR(5)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_flush(fl), .i_valid(vld),
        .i_mem_data(mdata), .i_addr_low(alow), .i_load_size(lsize), .i_load_unsigned(luns),
        .i_alu_result(alu), .i_extension(ext), .i_pc8(pc8), .i_rd(rd),
        .i_reg_write(rw), .i_mem_to_reg(m2r), .i_lui(lui), .i_jal(jal), .i_halt(hlt),
        .o_filterL(o_filterL), .o_extension(o_extension), .o_alu_result(o_alu_result),
        .o_pc8(o_pc8), .o_rd(o_rd), .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg),
        .o_lui(o_lui), .o_jal(o_jal), .o_valid(o_valid), .o_misaligned(o_misaligned),
        .o_halt(o_halt), .o_retired(o_retired)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_filter(input logic [31:0] d, input int a, input int sz, input bit u);
        logic [31:0] v;
        if (sz == 0) begin
            v = (d >> (8 * a)) & 32'h0000_00FF;
            if (!u && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (d >> (16 * (a / 2))) & 32'h0000_FFFF;
            if (!u && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic bit ref_misaligned(input bit load, input int a, input int sz);
        if (!load || sz == 0) return 1'b0;
        if (sz == 1) return (a % 2) == 1;
        return a != 0;
    endfunction

    task automatic model_reset();
        m_filter = 32'd0; m_ext = 32'd0; m_alu = 32'd0; m_pc8 = 32'd0; m_ret = 32'd0;
        m_rd = 5'd0; m_rw = 1'b0; m_m2r = 1'b0; m_lui = 1'b0; m_jal = 1'b0;
        m_valid = 1'b0; m_mis = 1'b0; m_halt = 1'b0;
    endtask

    task automatic model_edge();
        bit mis;
        if (en && !m_halt) begin
            if (fl || !vld) begin
                m_filter = 32'd0; m_ext = 32'd0; m_alu = 32'd0; m_pc8 = 32'd0;
                m_rd = 5'd0; m_rw = 1'b0; m_m2r = 1'b0; m_lui = 1'b0; m_jal = 1'b0;
                m_valid = 1'b0; m_mis = 1'b0;
            end else begin
                mis      = ref_misaligned(m2r, int'(alow), int'(lsize));
                m_filter = mis ? 32'd0 : ref_filter(mdata, int'(alow), int'(lsize), luns);
                m_ext = ext; m_alu = alu; m_pc8 = pc8; m_rd = rd;
                m_rw = rw && !mis; m_m2r = m2r; m_lui = lui; m_jal = jal;
                m_valid = 1'b1; m_mis = mis; m_halt = hlt;
                m_ret = m_ret + 32'd1;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        check_val({ctx, ".filterL"}, o_filterL, m_filter);
        check_val({ctx, ".extension"}, o_extension, m_ext);
        check_val({ctx, ".alu_result"}, o_alu_result, m_alu);
        check_val({ctx, ".pc8"}, o_pc8, m_pc8);
        check_val({ctx, ".rd"}, {27'd0, o_rd}, {27'd0, m_rd});
        check_val({ctx, ".ctrl"}, {28'd0, o_reg_write, o_mem_to_reg, o_lui, o_jal},
                  {28'd0, m_rw, m_m2r, m_lui, m_jal});
        check_val({ctx, ".valid"}, {31'd0, o_valid}, {31'd0, m_valid});
        check_val({ctx, ".misaligned"}, {31'd0, o_misaligned}, {31'd0, m_mis});
        check_val({ctx, ".halt"}, {31'd0, o_halt}, {31'd0, m_halt});
        check_val({ctx, ".retired"}, o_retired, m_ret);
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic set_load(input logic [31:0] d, input logic [1:0] a, input logic [1:0] sz, input logic u);
        en = 1'b1; fl = 1'b0; vld = 1'b1; hlt = 1'b0;
        mdata = d; alow = a; lsize = sz; luns = u;
        rw = 1'b1; m2r = 1'b1; lui = 1'b0; jal = 1'b0;
        alu = $urandom; ext = $urandom; pc8 = $urandom; rd = 5'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] held_ret;

    initial begin
        en = 1'b0; fl = 1'b0; vld = 1'b0; luns = 1'b0; rw = 1'b0; m2r = 1'b0;
        lui = 1'b0; jal = 1'b0; hlt = 1'b0; mdata = 32'd0; alu = 32'd0; ext = 32'd0;
        pc8 = 32'd0; alow = 2'd0; lsize = 2'd0; rd = 5'd0;
        model_reset();
        rst_n = 1'b0;
        #12;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a cycle after a valid word load.
        set_load(32'h1234_5678, 2'd0, 2'b11, 1'b0);
        step("word0");
        check_val("word0.filter_const", o_filterL, 32'h1234_5678);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        check_val("midreset.retired", o_retired, 32'd0);
        rst_n = 1'b1;

        // Byte lanes of 0x80FF7F01.
        set_load(32'h80FF_7F01, 2'd0, 2'b00, 1'b0); step("b0");
        check_val("byte0", o_filterL, 32'h0000_0001);
        set_load(32'h80FF_7F01, 2'd1, 2'b00, 1'b0); step("b1");
        check_val("byte1", o_filterL, 32'h0000_007F);
        set_load(32'h80FF_7F01, 2'd2, 2'b00, 1'b0); step("b2");
        check_val("byte2", o_filterL, 32'hFFFF_FFFF);
        set_load(32'h80FF_7F01, 2'd3, 2'b00, 1'b0); step("b3");
        check_val("byte3", o_filterL, 32'hFFFF_FF80);
        set_load(32'h80FF_7F01, 2'd3, 2'b00, 1'b1); step("b3u");
        check_val("byte3u", o_filterL, 32'h0000_0080);

        // Half and word loads, then a misaligned half.
        set_load(32'h8000_ABCD, 2'd2, 2'b01, 1'b0); step("h2");
        check_val("half2", o_filterL, 32'hFFFF_8000);
        set_load(32'h8000_ABCD, 2'd0, 2'b01, 1'b1); step("h0u");
        check_val("half0u", o_filterL, 32'h0000_ABCD);
        set_load(32'h8000_ABCD, 2'd0, 2'b11, 1'b0); step("w0");
        check_val("word", o_filterL, 32'h8000_ABCD);
        set_load(32'h8000_ABCD, 2'd1, 2'b01, 1'b0); step("h1");
        check_val("mis.flag", {31'd0, o_misaligned}, 32'd1);
        check_val("mis.regwrite", {31'd0, o_reg_write}, 32'd0);
        check_val("mis.filter", o_filterL, 32'd0);
        check_val("mis.retired", o_retired, 32'd9);

        // Stall for three cycles, then a flushed valid instruction.
        held_ret = o_retired;
        set_load(32'hDEAD_BEEF, 2'd0, 2'b11, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step("stall");
        check_val("stall.retired", o_retired, held_ret);
        en = 1'b1; fl = 1'b1;
        step("flush");
        check_val("flush.valid", {31'd0, o_valid}, 32'd0);
        check_val("flush.regwrite", {31'd0, o_reg_write}, 32'd0);
        check_val("flush.retired", o_retired, held_ret);
        hlt = 1'b1;
        step("flush_halt");
        check_val("flush_halt.halt", {31'd0, o_halt}, 32'd0);

        // Randomized traffic without halt.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 7) == 0);
            vld = ($urandom_range(0, 5) != 0);
            mdata = $urandom; alow = 2'($urandom); lsize = 2'($urandom); luns = 1'($urandom);
            alu = $urandom; ext = $urandom; pc8 = $urandom; rd = 5'($urandom);
            rw = 1'($urandom); m2r = 1'($urandom); lui = 1'($urandom); jal = 1'($urandom);
            hlt = 1'b0;
            step("rand");
        end

        // Halt on the fourth valid instruction, then freeze despite enable.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            set_load($urandom, 2'd0, 2'b11, 1'b0);
            rd = 5'(i);
            hlt = (i == 4);
            step("halt_seq");
        end
        for (int i = 0; i < 5; i++) begin
            set_load($urandom, 2'd0, 2'b11, 1'b0);
            rd = 5'd9;
            step("halted");
        end
        check_val("halt.flag", {31'd0, o_halt}, 32'd1);
        check_val("halt.retired", o_retired, 32'd4);
        check_val("halt.rd", {27'd0, o_rd}, 32'd4);

        // Counter wrap from a forced all-ones value.
        do_reset();
        en = 1'b0;
        force dut.r_retired = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.r_retired;
        m_ret = 32'hFFFF_FFFF;
        step("preload");
        check_val("wrap.pre", o_retired, 32'hFFFF_FFFF);
        set_load(32'h0000_0001, 2'd0, 2'b11, 1'b0);
        step("wrap");
        check_val("wrap.post", o_retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
